// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared TFT geometry constants and switch layout
package tft_pkg;
  localparam int TFT_X_RES      = 480;
  localparam int TFT_Y_RES      = 272;
  localparam int RECT_W         = 100;
  localparam int RECT_H         = 100;
  localparam int TFT_X_NUM_BITS = 10;
  localparam int TFT_Y_NUM_BITS = 9;

  // Largest corner that still keeps the whole rectangle on screen
  localparam int X_MAX  = TFT_X_RES - RECT_W;
  localparam int Y_MAX  = TFT_Y_RES - RECT_H;
  localparam int X_INIT = 190;
  localparam int Y_INIT = 86;

  typedef struct packed {
    logic       recenter;
    logic       freeze;
    logic [2:0] y_speed;
    logic [2:0] x_speed;
  } sw_t;
endpackage

// File: rtl/axis_bouncer.sv
// rtl/axis_bouncer.sv - one axis of corner motion, bouncing between 0 and MAX
module axis_bouncer #(
  parameter int WIDTH = 10,
  parameter int MAX   = 380,
  parameter int INIT  = 190
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [2:0]       speed,
  input  logic             freeze,
  input  logic             recenter,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             hit
);
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic [WIDTH-1:0] pos_q, pos_d, spd_n;
  logic             dir_q, dir_d;
  logic [WIDTH:0]   sum_w;

  assign spd_n = {{(WIDTH-3){1'b0}}, speed};
  // One extra bit so the +speed compare against MAX cannot wrap
  assign sum_w = {1'b0, pos_q} + {1'b0, spd_n};

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    hit   = 1'b0;
    if (tick) begin
      if (recenter) begin
        pos_d = INIT_W;
        dir_d = 1'b1;
      end else if (!freeze && speed != 3'd0) begin
        if (dir_q) begin
          if (sum_w >= MAX_W) begin
            pos_d = MAX_W[WIDTH-1:0];
            dir_d = 1'b0;
            hit   = 1'b1;
          end else begin
            pos_d = sum_w[WIDTH-1:0];
          end
        end else if (pos_q <= spd_n) begin
          pos_d = '0;
          dir_d = 1'b1;
          hit   = 1'b1;
        end else begin
          pos_d = pos_q - spd_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= INIT_W;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;
endmodule

// File: rtl/rect_motion_ctrl.sv
// rtl/rect_motion_ctrl.sv - per-frame rectangle corner motion, updated on entry to blanking
module rect_motion_ctrl
  import tft_pkg::*;
(
  input  logic                      tft_clk,
  input  logic                      rstb,
  input  logic                      new_frame,
  input  logic [7:0]                switches,
  output logic [TFT_X_NUM_BITS-1:0] xcorner,
  output logic [TFT_Y_NUM_BITS-1:0] ycorner,
  output logic                      dir_x,
  output logic                      dir_y,
  output logic                      bounce
);
  sw_t  sw_meta_q, sw_sync_q;
  logic new_frame_q, bounce_q, bounce_d;
  logic tick, hit_x, hit_y;

  // Falling edge of new_frame marks the start of vertical blanking
  assign tick     = ~new_frame & new_frame_q;
  assign bounce_d = hit_x | hit_y;

  always_ff @(posedge tft_clk or negedge rstb) begin
    if (!rstb) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      new_frame_q <= 1'b0;
      bounce_q    <= 1'b0;
    end else begin
      sw_meta_q   <= sw_t'(switches);
      sw_sync_q   <= sw_meta_q;
      new_frame_q <= new_frame;
      bounce_q    <= bounce_d;
    end
  end

  axis_bouncer #(.WIDTH(TFT_X_NUM_BITS), .MAX(X_MAX), .INIT(X_INIT)) u_x (
    .clk(tft_clk), .rst_n(rstb), .tick(tick), .speed(sw_sync_q.x_speed),
    .freeze(sw_sync_q.freeze), .recenter(sw_sync_q.recenter),
    .pos(xcorner), .dir(dir_x), .hit(hit_x)
  );

  axis_bouncer #(.WIDTH(TFT_Y_NUM_BITS), .MAX(Y_MAX), .INIT(Y_INIT)) u_y (
    .clk(tft_clk), .rst_n(rstb), .tick(tick), .speed(sw_sync_q.y_speed),
    .freeze(sw_sync_q.freeze), .recenter(sw_sync_q.recenter),
    .pos(ycorner), .dir(dir_y), .hit(hit_y)
  );

  assign bounce = bounce_q;
endmodule

// File: tb/tb_rect_motion_ctrl.sv
// tb/tb_rect_motion_ctrl.sv - directed bench with per-cycle behavioural model compare
module tb_rect_motion_ctrl;
  logic       tft_clk = 1'b0;
  logic       rstb, new_frame;
  logic [7:0] sw;
  logic [9:0] xcorner;
  logic [8:0] ycorner;
  logic       dir_x, dir_y, bounce;

  int n_cmp = 0;
  int n_bad = 0;

  int mx, my;
  bit mdx, mdy, mb, prev_nf;

  rect_motion_ctrl dut (
    .tft_clk(tft_clk), .rstb(rstb), .new_frame(new_frame), .switches(sw),
    .xcorner(xcorner), .ycorner(ycorner), .dir_x(dir_x), .dir_y(dir_y),
    .bounce(bounce)
  );

  always #5 tft_clk = ~tft_clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic axis(inout int p, inout bit d, input int s, input int m, output bit h);
    h = 1'b0;
    if (s == 0) return;
    if (d) begin
      if (p + s >= m) begin p = m; d = 1'b0; h = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1'b1; h = 1'b1; end
      else p = p - s;
    end
  endtask

  // Model: a frame ends when new_frame is seen high then low on successive edges
  initial begin
    bit hx, hy;
    forever begin
      @(posedge tft_clk or negedge rstb);
      if (!rstb) begin
        mx = 190; my = 86; mdx = 1'b1; mdy = 1'b1; mb = 1'b0; prev_nf = 1'b0;
      end else begin
        mb = 1'b0;
        if (prev_nf && !new_frame) begin
          if (sw[7]) begin
            mx = 190; my = 86; mdx = 1'b1; mdy = 1'b1;
          end else if (!sw[6]) begin
            axis(mx, mdx, int'(sw[2:0]), 380, hx);
            axis(my, mdy, int'(sw[5:3]), 172, hy);
            mb = hx | hy;
          end
        end
        prev_nf = new_frame;
      end
    end
  end

  initial begin
    forever begin
      @(negedge tft_clk);
      check("model_x", int'(xcorner), mx);
      check("model_y", int'(ycorner), my);
      check("model_dir_x", int'(dir_x), int'(mdx));
      check("model_dir_y", int'(dir_y), int'(mdy));
      check("model_bounce", int'(bounce), int'(mb));
    end
  end

  task automatic set_sw(input logic [7:0] v);
    @(posedge tft_clk); #2 sw = v;
    repeat (3) @(posedge tft_clk);
  endtask

  // Returns 3 time units after the edge on which the tick takes effect
  task automatic frame(input int hi);
    @(posedge tft_clk); #2 new_frame = 1'b1;
    repeat (hi) @(posedge tft_clk);
    #2 new_frame = 1'b0;
    @(posedge tft_clk); #3;
  endtask

  task automatic check_all(input string tag, input int x, input int y,
                           input int dx, input int dy, input int b);
    check({tag, "_x"}, int'(xcorner), x);
    check({tag, "_y"}, int'(ycorner), y);
    check({tag, "_dir_x"}, int'(dir_x), dx);
    check({tag, "_dir_y"}, int'(dir_y), dy);
    check({tag, "_bounce"}, int'(bounce), b);
  endtask

  initial begin
    rstb = 1'b0; new_frame = 1'b0; sw = 8'h00;
    // 1: reset values hold while new_frame toggles
    for (int i = 0; i < 6; i++) begin
      @(posedge tft_clk); #2 new_frame = ~new_frame;
    end
    #1 check_all("reset", 190, 86, 1, 1, 0);
    @(posedge tft_clk); #2 new_frame = 1'b0; rstb = 1'b1;

    // 2: x speed 2, y speed 1, long visible line
    set_sw(8'b00_001_010);
    @(posedge tft_clk); #2 new_frame = 1'b1;
    repeat (524) @(posedge tft_clk);
    #1 check_all("hold_while_high", 190, 86, 1, 1, 0);
    @(posedge tft_clk); #1 new_frame = 1'b0;
    @(posedge tft_clk); #3 check_all("first_tick", 192, 87, 1, 1, 0);

    // 3: climb to 378 then bounce off the right wall
    set_sw(8'b00_000_010);
    repeat (93) frame(1);
    check("x_at_378", int'(xcorner), 378);
    set_sw(8'b00_000_101);
    frame(2);
    check_all("right_wall", 380, 87, 0, 1, 1);
    @(posedge tft_clk); #3 check("bounce_one_cycle", int'(bounce), 0);
    frame(2);
    check_all("after_wall", 375, 87, 0, 1, 0);

    // 4: bring x to 3 heading -x and y to 171 heading +y, then hit both walls
    set_sw(8'b00_000_100);
    repeat (93) frame(1);
    set_sw(8'b00_001_000);
    repeat (84) frame(1);
    check_all("pre_corner", 3, 171, 0, 1, 0);
    set_sw(8'b00_001_111);
    frame(2);
    check_all("corner", 0, 172, 1, 0, 1);
    @(posedge tft_clk); #3 check("corner_single_pulse", int'(bounce), 0);

    // 5: freeze holds, recenter wins over freeze
    set_sw(8'b01_011_011);
    repeat (3) frame(2);
    check_all("frozen", 0, 172, 1, 0, 0);
    set_sw(8'b11_011_011);
    frame(2);
    check_all("recenter", 190, 86, 1, 1, 0);

    // 6: reset while new_frame high, then one real falling edge
    set_sw(8'b00_010_011);
    frame(2);
    check_all("pre_reset", 193, 88, 1, 1, 0);
    @(posedge tft_clk); #2 new_frame = 1'b1;
    repeat (2) @(posedge tft_clk);
    #2 rstb = 1'b0;
    repeat (2) @(posedge tft_clk);
    #2 rstb = 1'b1;
    repeat (5) @(posedge tft_clk);
    #1 check_all("after_release", 190, 86, 1, 1, 0);
    #1 new_frame = 1'b0;
    @(posedge tft_clk); #3 check_all("post_reset_tick", 193, 88, 1, 1, 0);
    repeat (4) @(posedge tft_clk);
    #3 check_all("idle_hold", 193, 88, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
